// File: rtl/neuron_arbiter.sv
// Round-robin arbiter that time-shares one neuron datapath among NREQ requesters.
// A grant latches the winner's operands, holds them on dp_in for LAT cycles, then captures the result.
module neuron_arbiter #(
  parameter int N    = 8,
  parameter int NIN  = 8,
  parameter int NREQ = 4,
  parameter int LAT  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*NIN*N-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NIN*N-1:0]        dp_in,
  output logic                    dp_busy,
  input  logic [N-1:0]            dp_result,
  input  logic                    dp_neg,
  output logic [NREQ-1:0]         done,
  output logic [N-1:0]            rsp_data,
  output logic                    rsp_neg
);

  localparam int DW = NIN * N;
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t          r_state, w_next;
  logic [IW-1:0]   r_ptr, r_sel, w_win;
  logic            w_found;
  logic [DW-1:0]   r_ops, w_ops;
  logic [CW-1:0]   r_cnt;
  logic [NREQ-1:0] r_gnt, r_done;
  logic [N-1:0]    r_rsp;
  logic            r_neg;

  // Two passes: first requesters at or above the pointer, then wrap to the lowest one.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_ops   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[i] && (i >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = IW'(i);
        w_ops   = req_data[i*DW +: DW];
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!w_found && req[i]) begin
        w_found = 1'b1;
        w_win   = IW'(i);
        w_ops   = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_found) w_next = EVAL;
      EVAL:    if (r_cnt == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_sel  <= '0;
      r_cnt  <= '0;
      r_ops  <= '0;
      r_gnt  <= '0;
      r_done <= '0;
      r_rsp  <= '0;
      r_neg  <= 1'b0;
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
      case (r_state)
        IDLE: if (w_found) begin
          r_sel <= w_win;
          r_ops <= w_ops;
          r_cnt <= CW'(LAT - 1);
          r_gnt <= NREQ'(1) << w_win;
          r_ptr <= (w_win == IW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        end
        EVAL: if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end else begin
          r_rsp  <= dp_result;
          r_neg  <= dp_neg;
          r_done <= NREQ'(1) << r_sel;
        end
        default: ;
      endcase
    end
  end

  assign dp_busy  = (r_state == EVAL);
  assign dp_in    = dp_busy ? r_ops : '0;
  assign gnt      = r_gnt;
  assign done     = r_done;
  assign rsp_data = r_rsp;
  assign rsp_neg  = r_neg;

endmodule

// File: tb/tb_neuron_arbiter.sv
// Directed + randomized bench for neuron_arbiter with a ReLU-of-sum datapath stand-in
// and a transaction-level round-robin reference model.
module tb_neuron_arbiter;
  localparam int N = 8, NIN = 8, NREQ = 4, LAT = 2, DW = NIN * N;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   gnt, done;
  logic [DW-1:0]     dp_in;
  logic              dp_busy;
  logic [N-1:0]      dp_result, rsp_data;
  logic              dp_neg, rsp_neg;

  // dmode=1 drives the datapath inputs directly from dres/dneg
  logic              dmode;
  logic [N-1:0]      dres;
  logic              dneg;
  logic [N-1:0]      w_sum;

  int n_tests = 0, n_fail = 0, mp = 0;
  logic [N-1:0] last_res;
  logic         last_neg;

  neuron_arbiter #(.N(N), .NIN(NIN), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .dp_in(dp_in), .dp_busy(dp_busy), .dp_result(dp_result), .dp_neg(dp_neg),
    .done(done), .rsp_data(rsp_data), .rsp_neg(rsp_neg)
  );

  function automatic logic [N-1:0] sum_ops(input logic [DW-1:0] ops);
    logic [N-1:0] s = '0;
    for (int j = 0; j < NIN; j++) s = s + ops[j*N +: N];
    return s;
  endfunction

  assign w_sum     = sum_ops(dp_in);
  assign dp_result = dmode ? dres : (w_sum[N-1] ? '0 : w_sum);
  assign dp_neg    = dmode ? dneg : w_sum[N-1];

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++)
      if (r[(mp + k) % NREQ]) return (mp + k) % NREQ;
    return 0;
  endfunction

  task automatic rand_data();
    for (int i = 0; i < NREQ*DW/32; i++) req_data[i*32 +: 32] = $urandom;
  endtask

  // One full grant/eval/done transaction from IDLE. scramble: 0 none, 1 new data + req dropped, 2 new data + random req.
  task automatic run_txn(input logic [NREQ-1:0] r, input int scramble);
    int w, cyc;
    logic [DW-1:0] eops;
    logic [N-1:0]  s, eres;
    logic          eneg;
    w    = rr_pick(r);
    eops = req_data[w*DW +: DW];
    s    = sum_ops(eops);
    eres = dmode ? dres : (s[N-1] ? '0 : s);
    eneg = dmode ? dneg : s[N-1];
    req  = r;
    cyc  = 0;
    do begin step(); cyc++; end while (gnt == '0 && cyc < 8);
    chk("gnt_latency", cyc, 1);
    if (gnt == '0) begin req = '0; return; end
    chk("gnt", gnt, NREQ'(1) << w);
    chk("busy_first", dp_busy, 1);
    chk("dp_in_first", dp_in, eops);
    mp = (w + 1) % NREQ;
    if (scramble > 0) begin
      rand_data();
      req = (scramble == 2) ? NREQ'($urandom) : '0;
    end
    for (int k = 1; k < LAT; k++) begin
      step();
      chk("eval_gnt", gnt, 0);
      chk("eval_done", done, 0);
      chk("eval_busy", dp_busy, 1);
      chk("eval_dp_in", dp_in, eops);
    end
    step();
    chk("done", done, NREQ'(1) << w);
    chk("rsp_data", rsp_data, eres);
    chk("rsp_neg", rsp_neg, eneg);
    chk("done_busy", dp_busy, 0);
    chk("done_dp_in", dp_in, 0);
    chk("done_gnt", gnt, 0);
    last_res = eres;
    last_neg = eneg;
    req = '0;
    step();
    chk("post_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_g, cyc, last;
    rst_n = 1'b0; req = '0; dmode = 1'b0; dres = '0; dneg = 1'b0;
    rand_data();
    repeat (3) step();
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", dp_busy, 0);
    chk("rst_dp_in", dp_in, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_neg", rsp_neg, 0);
    rst_n = 1'b1;
    step();

    // Fairness with all requesting; first grant after reset goes to requester 0
    mp = 0; req = '1; n_g = 0; cyc = 0; last = 0;
    while (n_g < 16 && cyc < 100) begin
      step(); cyc++;
      if (gnt != '0) begin
        chk("fair_gnt", gnt, NREQ'(1) << mp);
        if (n_g > 0) chk("fair_spacing", cyc - last, LAT + 2);
        last = cyc;
        mp = (mp + 1) % NREQ;
        n_g++;
      end
    end
    chk("fair_count", n_g, 16);
    req = '0;
    repeat (LAT + 1) step();

    // Single request with fixed datapath result
    rand_data();
    req_data[0 +: DW] = {NIN{8'h10}};
    dmode = 1'b1; dres = 8'h20; dneg = 1'b0;
    run_txn(4'b0001, 0);

    // Negative sum forces a zero result
    dres = 8'h00; dneg = 1'b1;
    run_txn(4'b0001, 0);

    // Operand/req change after grant must not disturb the operation
    dmode = 1'b0;
    rand_data();
    run_txn(4'b0010, 1);

    // Randomized requests against the reference model
    for (int t = 0; t < 30; t++) begin
      rand_data();
      run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), 2);
    end

    // Idle: nothing moves, response holds
    req = '0;
    for (int t = 0; t < 20; t++) begin
      step();
      chk("idle_gnt", gnt, 0);
      chk("idle_done", done, 0);
      chk("idle_busy", dp_busy, 0);
      chk("idle_dp_in", dp_in, 0);
      chk("idle_rsp_hold", rsp_data, last_res);
      chk("idle_neg_hold", rsp_neg, last_neg);
    end

    // Reset in the second EVAL cycle aborts without done
    rand_data();
    req = 4'b0001;
    step();
    chk("mid_gnt", gnt, 4'b0001);
    req = '0;
    step();
    chk("mid_busy", dp_busy, 1);
    rst_n = 1'b0;
    step();
    chk("abort_gnt", gnt, 0);
    chk("abort_done", done, 0);
    chk("abort_rsp", rsp_data, 0);
    chk("abort_neg", rsp_neg, 0);
    chk("abort_dp_in", dp_in, 0);
    chk("abort_busy", dp_busy, 0);
    step();
    chk("abort_done2", done, 0);
    rst_n = 1'b1;
    mp = 0;
    req = 4'b0100;
    step();
    chk("post_rst_gnt", gnt, 4'b0100);
    req = '0;
    repeat (LAT + 2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/neuron_arbiter.md
NEURON_ARBITER -- requirements
Module: neuron_arbiter

Interface
REQ-001 Parameter N, default 8, width of each neuron input operand and of the neuron result.
REQ-002 Parameter NIN, default 8, number of operands per neuron evaluation.
REQ-003 Parameter NREQ, default 4, number of requesters sharing one neuron datapath (adder tree plus output mux).
REQ-004 Parameter LAT, default 2, minimum 1, datapath settle time in clock cycles.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req  input  NREQ  per-requester evaluation request, level-sensitive.
REQ-008 req_data  input  NREQ*NIN*N  packed operand sets; requester i occupies bits [(i+1)*NIN*N-1 : i*NIN*N].
REQ-009 gnt  output  NREQ  one-hot grant pulse.
REQ-010 dp_in  output  NIN*N  operands driven to the shared datapath, operand j at bits [(j+1)*N-1 : j*N].
REQ-011 dp_busy  output  1  high while dp_in carries a granted operand set.
REQ-012 dp_result  input  N  datapath mux output.
REQ-013 dp_neg  input  1  datapath sum MSB (mux select; result forced to zero).
REQ-014 done  output  NREQ  one-hot completion pulse to the granted requester.
REQ-015 rsp_data  output  N  captured dp_result.
REQ-016 rsp_neg  output  1  captured dp_neg.

Function
REQ-017 The FSM SHALL have three states: IDLE, EVAL, DONE.
REQ-018 In IDLE with req nonzero at an edge: latch winner index into sel, req_data[winner] into the operand register, load cnt with LAT-1, set gnt to onehot(winner), go to EVAL.
REQ-019 In IDLE with req zero: remain in IDLE; no output changes except gnt and done held at zero.
REQ-020 Arbitration SHALL be round-robin: search starts at pointer ptr, ascending with wrap from NREQ-1 to 0; after a grant, ptr <= (winner+1) mod NREQ.
REQ-021 gnt SHALL be high for exactly one cycle, the first EVAL cycle.
REQ-022 dp_in SHALL equal the operand register and dp_busy SHALL be 1 in EVAL; dp_in SHALL be all-zero and dp_busy 0 in IDLE and DONE.
REQ-023 In EVAL with cnt nonzero: decrement cnt; with cnt zero: rsp_data <= dp_result, rsp_neg <= dp_neg, done <= onehot(sel), go to DONE.
REQ-024 done SHALL be high for exactly one cycle (the DONE cycle), LAT cycles after the gnt cycle; DONE always returns to IDLE.
REQ-025 rsp_data and rsp_neg SHALL hold their value until the next capture.
REQ-026 Requester data need be stable only in the cycle before gnt; later req_data changes SHALL NOT affect the operation in progress.
REQ-027 req deasserted during EVAL SHALL NOT abort the operation; done is still delivered.
REQ-028 req changes during EVAL/DONE SHALL be ignored until the next IDLE sample; back-to-back grant period is LAT+2 cycles.
REQ-029 Multiple simultaneous requests SHALL produce exactly one grant; losers wait with no state loss.

Reset
REQ-030 With rst_n low at an edge: state <= IDLE, ptr <= 0, sel <= 0, cnt <= 0, operand register <= 0, gnt <= 0, done <= 0, rsp_data <= 0, rsp_neg <= 0.
REQ-031 Reset asserted during EVAL or DONE SHALL abort the operation with no done pulse, and dp_in SHALL be zero from the following cycle.
REQ-032 The first grant after reset release SHALL favour requester 0 if requesting.

Verification
REQ-033 Single request: req=0001, operands all 8'h10, model dp_result=8'h20, dp_neg=0 -> gnt=0001 in cycle c, done=0001 in cycle c+2, rsp_data=8'h20, dp_busy high for 2 cycles.
REQ-034 Fairness: req=1111 held for 16 grants -> grant order 0,1,2,3 repeated, each requester granted 4 times, grants spaced 4 cycles.
REQ-035 Negative sum: dp_neg=1, dp_result=8'h00 -> done pulse with rsp_neg=1, rsp_data=8'h00.
REQ-036 Data/req change after grant: req_data[1] changed and req[1] dropped one cycle after gnt=0010 -> dp_in stays at the original operands; done=0010 still issued.
REQ-037 Reset mid-op: rst_n low in second EVAL cycle -> no done, gnt/done/rsp_data zero, dp_in zero; next req=0100 -> gnt=0100.
REQ-038 Idle check: req=0 for 20 cycles -> gnt, done, dp_busy stay 0, dp_in stays zero.
